// File: rtl/cache_arbiter_rr.sv
// -----------------------------------------------------------------------------
// cache_arbiter_rr
//   Funnels line-sized read/write requests from NUM_PORTS L1 caches onto one
//   downstream memory port. Only one transaction is outstanding at a time.
//   Arbitration is round-robin (PRIO_MODE = 0) or fixed priority with the
//   lowest index winning (PRIO_MODE = 1). All outputs are registered.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   req_read     per-port read request, held until that port's req_resp bit
//   req_write    per-port write request, held until that port's req_resp bit
//   req_address  per-port line address, port i in bits [32i+31:32i]
//   req_wdata    per-port write line, port i in slice i
//   req_resp     one-cycle completion pulse to the granted port
//   req_rdata    last read line, shared, valid while req_resp is high
//   mem_read     downstream read strobe
//   mem_write    downstream write strobe
//   mem_address  downstream line address
//   mem_wdata    downstream write line
//   mem_resp     downstream completion
//   mem_rdata    downstream read line, valid with mem_resp
// -----------------------------------------------------------------------------
module cache_arbiter_rr #(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned S_LINE    = 256,
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req_read,
   input  logic [NUM_PORTS-1:0]          req_write,
   input  logic [32*NUM_PORTS-1:0]       req_address,
   input  logic [S_LINE*NUM_PORTS-1:0]   req_wdata,
   output logic [NUM_PORTS-1:0]          req_resp,
   output logic [S_LINE-1:0]             req_rdata,
   output logic                          mem_read,
   output logic                          mem_write,
   output logic [31:0]                   mem_address,
   output logic [S_LINE-1:0]             mem_wdata,
   input  logic                          mem_resp,
   input  logic [S_LINE-1:0]             mem_rdata
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                 r_state;
   logic [PW-1:0]          r_rr_ptr;
   logic [PW-1:0]          r_grant;
   logic                   r_mem_read;
   logic                   r_mem_write;
   logic [31:0]            r_mem_address;
   logic [S_LINE-1:0]      r_mem_wdata;
   logic [S_LINE-1:0]      r_rdata;
   logic [NUM_PORTS-1:0]   r_req_resp;

   logic [NUM_PORTS-1:0]   w_pending;
   logic                   w_any;
   logic [PW-1:0]          w_sel;
   logic                   w_sel_write;
   logic [31:0]            w_sel_addr;
   logic [S_LINE-1:0]      w_sel_wdata;
   logic [NUM_PORTS-1:0]   w_grant_oh;
   logic [PW-1:0]          w_rr_next;

   assign w_pending = req_read | req_write;
   assign w_any     = |w_pending;

   // Grant selection. Round-robin scans upward from r_rr_ptr; the wrap is an
   // explicit compare so non-power-of-two port counts never alias.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      w_sel = '0;
      for (int unsigned off = 0; off < NUM_PORTS; off++) begin
         if (PRIO_MODE != 0) begin
            idx = off;
         end else begin
            idx = 32'(r_rr_ptr) + off;
            if (idx >= NUM_PORTS) begin
               idx = idx - NUM_PORTS;
            end
         end
         if (!found && w_pending[idx[PW-1:0]]) begin
            found = 1'b1;
            w_sel = idx[PW-1:0];
         end
      end
   end

   // Per-port fields of the selected port; write wins when both ops are high.
   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (w_sel == PW'(p)) begin
            w_sel_write = req_write[p];
            w_sel_addr  = req_address[p*32 +: 32];
            w_sel_wdata = req_wdata[p*S_LINE +: S_LINE];
         end
      end
   end

   always_comb begin
      w_grant_oh = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_grant_oh[p] = (r_grant == PW'(p));
      end
   end

   assign w_rr_next = (r_grant == PW'(NUM_PORTS - 1)) ? '0 : r_grant + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_rr_ptr      <= '0;
         r_grant       <= '0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_address <= '0;
         r_mem_wdata   <= '0;
         r_rdata       <= '0;
         r_req_resp    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               // mem_resp is deliberately ignored here.
               if (w_any) begin
                  r_grant       <= w_sel;
                  r_mem_address <= w_sel_addr;
                  r_mem_wdata   <= w_sel_wdata;
                  r_mem_write   <= w_sel_write;
                  r_mem_read    <= ~w_sel_write;
                  r_state       <= StBusy;
               end
            end
            StBusy: begin
               if (mem_resp) begin
                  // A write leaves the previous read line visible.
                  if (r_mem_read) begin
                     r_rdata <= mem_rdata;
                  end
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_req_resp  <= w_grant_oh;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               r_req_resp <= '0;
               if (PRIO_MODE == 0) begin
                  r_rr_ptr <= w_rr_next;
               end
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign req_resp    = r_req_resp;
   assign req_rdata   = r_rdata;
   assign mem_read    = r_mem_read;
   assign mem_write   = r_mem_write;
   assign mem_address = r_mem_address;
   assign mem_wdata   = r_mem_wdata;

endmodule
